// File: rtl/hicore_rsp_tracker.sv
// hicore_rsp_tracker: in-order outstanding tracker for a valid/ready memory port.
// Pairs responses with issued addresses and drops responses killed by a flush.
module hicore_rsp_tracker #(
  parameter int OUTS = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [AW-1:0]          req_addr,
  output logic                   cmd_vld,
  input  logic                   cmd_rdy,
  output logic [AW-1:0]          cmd_addr,
  input  logic                   rsp_vld,
  output logic                   rsp_rdy,
  input  logic [DW-1:0]          rsp_dat,
  input  logic                   rsp_err,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [DW-1:0]          o_dat,
  output logic                   o_err,
  output logic [AW-1:0]          o_addr,
  input  logic                   flush,
  output logic [$clog2(OUTS):0]  outs_cnt
);

  localparam int IW = $clog2(OUTS);
  localparam int PW = IW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [AW-1:0]   addr_q [OUTS];
  logic [OUTS-1:0] stale_q;
  logic [OUTS-1:0] occ;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic            full;
  logic            empty;
  logic            head_stale;
  logic            issue;
  logic            retire;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];
  assign full   = (wr_ptr[IW] != rd_ptr[IW]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr == rd_ptr);

  assign outs_cnt = wr_ptr - rd_ptr;

  assign cmd_vld  = req_vld & ~full & ~flush;
  assign req_rdy  = cmd_rdy & ~full & ~flush;
  assign cmd_addr = req_addr;
  assign issue    = cmd_vld & cmd_rdy;

  assign head_stale = stale_q[rd_idx] | flush;
  assign o_vld      = rsp_vld & ~empty & ~head_stale;
  assign rsp_rdy    = ~empty & (head_stale | o_rdy);
  assign o_addr     = addr_q[rd_idx];
  assign o_dat      = rsp_dat;
  assign o_err      = rsp_err;
  assign retire     = rsp_vld & rsp_rdy;

  // An entry is occupied if its distance from the head is below the count
  always_comb begin
    occ = '0;
    for (int i = 0; i < OUTS; i++) begin
      occ[i] = ({1'b0, IW'(i) - rd_idx} < outs_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      addr_q[wr_idx] <= req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      stale_q <= '0;
    end else begin
      for (int i = 0; i < OUTS; i++) begin
        if (flush && occ[i]) begin
          stale_q[i] <= 1'b1;
        end
      end
      if (retire) begin
        stale_q[rd_idx] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (issue) begin
        stale_q[wr_idx] <= 1'b0;
        wr_ptr          <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hicore_rsp_tracker.sv
// tb_hicore_rsp_tracker: directed plus random stimulus against a queue model.
// The model tracks outstanding transactions as a list of {addr, stale}.
module tb_hicore_rsp_tracker;

  localparam int OUTS = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = $clog2(OUTS) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_addr;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          o_err;
  logic [AW-1:0] o_addr;
  logic          flush;
  logic [CW-1:0] outs_cnt;

  int pass_cnt = 0;
  int total    = 0;

  logic [AW-1:0] mq_addr [$];
  bit            mq_stale[$];

  bit exp_req_rdy;
  bit exp_cmd_vld;
  bit exp_o_vld;
  bit exp_rsp_rdy;

  always #5 clk = ~clk;

  hicore_rsp_tracker #(.OUTS(OUTS), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_addr (req_addr),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_addr (cmd_addr),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy),
    .o_dat    (o_dat),
    .o_err    (o_err),
    .o_addr   (o_addr),
    .flush    (flush),
    .outs_cnt (outs_cnt)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic drive(bit rv, logic [AW-1:0] ra, bit cr, bit sv,
                       logic [DW-1:0] sd, bit se, bit ordy, bit fl);
    req_vld  = rv;
    req_addr = ra;
    cmd_rdy  = cr;
    rsp_vld  = sv;
    rsp_dat  = sd;
    rsp_err  = se;
    o_rdy    = ordy;
    flush    = fl;
  endtask

  task automatic idle();
    drive(0, '0, 1, 0, '0, 0, 1, 0);
  endtask

  // Settle combinational outputs and compare against the queue model
  task automatic pre();
    int  n;
    bit  hs;
    #1;
    n  = mq_addr.size();
    hs = (n > 0) ? (mq_stale[0] || flush) : 1'b0;
    exp_req_rdy = cmd_rdy && (n < OUTS) && !flush;
    exp_cmd_vld = req_vld && (n < OUTS) && !flush;
    exp_o_vld   = rsp_vld && (n > 0) && !hs;
    exp_rsp_rdy = (n > 0) && (hs || o_rdy);
    chk("outs_cnt", 64'(outs_cnt), 64'(n));
    chk("req_rdy", 64'(req_rdy), 64'(exp_req_rdy));
    chk("cmd_vld", 64'(cmd_vld), 64'(exp_cmd_vld));
    chk("cmd_addr", 64'(cmd_addr), 64'(req_addr));
    chk("o_vld", 64'(o_vld), 64'(exp_o_vld));
    chk("rsp_rdy", 64'(rsp_rdy), 64'(exp_rsp_rdy));
    if (n > 0) chk("o_addr", 64'(o_addr), 64'(mq_addr[0]));
    if (exp_o_vld) begin
      chk("o_dat", 64'(o_dat), 64'(rsp_dat));
      chk("o_err", 64'(o_err), 64'(rsp_err));
    end
  endtask

  task automatic tick();
    bit ret;
    bit iss;
    ret = rsp_vld && exp_rsp_rdy;
    iss = exp_cmd_vld && cmd_rdy;
    @(posedge clk);
    if (flush) begin
      foreach (mq_stale[i]) mq_stale[i] = 1'b1;
    end
    if (ret) begin
      void'(mq_addr.pop_front());
      void'(mq_stale.pop_front());
    end
    if (iss) begin
      mq_addr.push_back(req_addr);
      mq_stale.push_back(1'b0);
    end
    @(negedge clk);
  endtask

  task automatic step();
    pre();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cmd_rdy = 1'b0;
    #1;
    chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
    chk("rst_rsp_rdy", 64'(rsp_rdy), 64'd0);
    chk("rst_o_vld", 64'(o_vld), 64'd0);
    chk("rst_outs_cnt", 64'(outs_cnt), 64'd0);
    cmd_rdy = 1'b1;
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transaction
    drive(1, 32'h0000_1000, 1, 0, '0, 0, 1, 0);
    step();
    idle();
    pre();
    chk("t1_cnt1", 64'(outs_cnt), 64'd1);
    tick();
    drive(0, '0, 1, 1, 32'hDEADBEEF, 0, 1, 0);
    pre();
    chk("t1_o_vld", 64'(o_vld), 64'd1);
    chk("t1_o_addr", 64'(o_addr), 64'h1000);
    chk("t1_o_dat", 64'(o_dat), 64'hDEADBEEF);
    tick();
    idle();
    pre();
    chk("t1_cnt0", 64'(outs_cnt), 64'd0);
    chk("t1_o_vld_off", 64'(o_vld), 64'd0);
    tick();

    // Fill to capacity, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 1, 0, '0, 0, 1, 0);
      step();
    end
    drive(1, 32'h10, 1, 0, '0, 0, 1, 0);
    pre();
    chk("t2_full_cnt", 64'(outs_cnt), 64'd4);
    chk("t2_full_rdy", 64'(req_rdy), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 1, 32'(i + 100), 0, 1, 0);
      pre();
      chk("t2_o_addr", 64'(o_addr), 64'(i * 4));
      chk("t2_o_vld", 64'(o_vld), 64'd1);
      tick();
    end

    // Flush with three outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(32'h20 + i * 4), 1, 0, '0, 0, 1, 0);
      step();
    end
    drive(0, '0, 1, 0, '0, 0, 1, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 1, 32'hBAD0 + 32'(i), 0, 1, 0);
      pre();
      chk("t3_stale_o_vld", 64'(o_vld), 64'd0);
      chk("t3_stale_rsp_rdy", 64'(rsp_rdy), 64'd1);
      tick();
    end
    idle();
    pre();
    chk("t3_cnt0", 64'(outs_cnt), 64'd0);
    tick();
    drive(1, 32'h40, 1, 0, '0, 0, 1, 0);
    step();
    drive(0, '0, 1, 1, 32'h1234, 0, 1, 0);
    pre();
    chk("t3_live_o_vld", 64'(o_vld), 64'd1);
    chk("t3_live_o_addr", 64'(o_addr), 64'h40);
    tick();

    // Flush coinciding with a head response
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(32'h80 + i * 4), 1, 0, '0, 0, 1, 0);
      step();
    end
    drive(0, '0, 1, 1, 32'h5555, 0, 1, 1);
    pre();
    chk("t4_o_vld", 64'(o_vld), 64'd0);
    chk("t4_rsp_rdy", 64'(rsp_rdy), 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, '0, 1, 1, 32'h6666, 1, 1, 0);
      pre();
      chk("t4_drop_o_vld", 64'(o_vld), 64'd0);
      tick();
    end

    // Backpressure from the pipeline
    drive(1, 32'hC0, 1, 0, '0, 0, 1, 0);
    step();
    drive(0, '0, 1, 1, 32'h7777, 1, 0, 0);
    pre();
    chk("t5_hold_rsp_rdy", 64'(rsp_rdy), 64'd0);
    tick();
    pre();
    chk("t5_held_cnt", 64'(outs_cnt), 64'd1);
    tick();
    o_rdy = 1'b1;
    pre();
    chk("t5_deliver", 64'(o_vld), 64'd1);
    chk("t5_err", 64'(o_err), 64'd1);
    tick();
    idle();
    pre();
    chk("t5_once", 64'(o_vld), 64'd0);
    tick();

    // Back-to-back issue/retire across the pointer wrap
    drive(1, 32'h200, 1, 0, '0, 0, 1, 0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 32'(32'h200 + i * 4), 1, 1, 32'(i), 0, 1, 0);
      pre();
      chk("t6_cnt", 64'(outs_cnt), 64'd1);
      chk("t6_o_addr", 64'(o_addr), 64'(32'h200 + (i - 1) * 4));
      tick();
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0,
            (mq_addr.size() > 0) && ($urandom_range(0, 1) == 1),
            $urandom, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      step();
    end

    // Reset mid-stream
    drive(1, 32'h300, 1, 0, '0, 0, 1, 0);
    step();
    step();
    drive(0, '0, 1, 1, 32'h9, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cnt", 64'(outs_cnt), 64'd0);
    chk("rst_mid_o_vld", 64'(o_vld), 64'd0);
    mq_addr.delete();
    mq_stale.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    drive(1, 32'h400, 1, 0, '0, 0, 1, 0);
    step();
    drive(0, '0, 1, 1, 32'hA, 0, 1, 0);
    pre();
    chk("rst_after_addr", 64'(o_addr), 64'h400);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hicore_rsp_tracker.md
Name: hicore_rsp_tracker

Overview:
- Sits on the receive side of a valid/ready memory interface, for example between the IFU and the instruction bus.
- Forwards requests to memory as commands and records each issued address in an in-order outstanding queue.
- Pairs each returning response with its address and hands it to the pipeline.
- On a flush (branch), marks every in-flight transaction stale. Responses for stale transactions are absorbed and dropped, never delivered.

Parameters:
OUTS, 4, maximum outstanding transactions; power of 2, at least 2.
AW, 32, address width.
DW, 32, response data width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_vld  input  1  request valid from the pipeline.
req_rdy  output  1  request accepted.
req_addr  input  AW  request address.
cmd_vld  output  1  command valid to memory.
cmd_rdy  input  1  memory accepts the command.
cmd_addr  output  AW  command address, equal to req_addr.
rsp_vld  input  1  memory response valid.
rsp_rdy  output  1  response consumed.
rsp_dat  input  DW  response data.
rsp_err  input  1  response bus error.
o_vld  output  1  live response valid to the pipeline.
o_rdy  input  1  pipeline accepts the response.
o_dat  output  DW  equal to rsp_dat.
o_err  output  1  equal to rsp_err.
o_addr  output  AW  address of the head outstanding entry.
flush  input  1  single-cycle pulse; kills all in-flight transactions.
outs_cnt  output  clog2(OUTS)+1  current outstanding count.

Behaviour:
- Storage: an OUTS-entry circular queue holding {addr, stale} per entry.
  - wr_ptr and rd_ptr are each clog2(OUTS)+1 bits; the MSB is the wrap bit.
  - full: MSBs differ and lower bits are equal. empty: pointers are equal.
- Reset (asynchronous): wr_ptr=0, rd_ptr=0, all stale bits=0, outs_cnt=0.
  - Outputs after reset: req_rdy=1, cmd_vld=0, rsp_rdy=0, o_vld=0.
  - Address storage is not reset.
- Command path: combinational pass-through with zero latency.
  - cmd_vld = req_vld & ~full & ~flush.
  - req_rdy = cmd_rdy & ~full & ~flush.
  - cmd_addr = req_addr.
  - Issue event: cmd_vld & cmd_rdy. It writes {req_addr, 0} at wr_ptr and increments wr_ptr.
- Head stale: head_stale = stale[rd_ptr] | flush.
- Response path (combinational), defined only when the queue is not empty:
  - o_vld = rsp_vld & ~empty & ~head_stale.
  - rsp_rdy = ~empty & (head_stale | o_rdy).
  - o_addr = addr[rd_ptr].
  - Retire event: rsp_vld & rsp_rdy. It increments rd_ptr and clears that entry's stale bit.
- Empty queue: rsp_rdy=0 and o_vld=0. A response arriving with nothing outstanding is a protocol violation; the block holds it off and does not consume it.
- Flush cycle:
  - Every currently occupied entry, including the head, gets stale=1 on the next edge.
  - No new issue happens in that cycle.
  - A response present in that cycle is retired as stale and is not delivered.
  - flush while empty has no effect.
- Simultaneous issue and retire: both pointers advance and outs_cnt is unchanged.
- outs_cnt = wr_ptr - rd_ptr, taken modulo 2^(clog2(OUTS)+1); range 0..OUTS.
- Wrap-around: pointers roll over silently; ordering is preserved across the wrap.
- Full queue: req_rdy=0 and cmd_vld=0 until a retire. A retire in the same cycle does not unblock an issue (no ready bypass).
- Ordering: responses are strictly in order; the head entry always matches the next response.
- Reset mid-operation: the queue is cleared immediately. Responses the memory returns for pre-reset commands are not tracked; the system resets memory together with this block.

Test Plan:
1. Single transaction, cmd_rdy=1, rsp 2 cycles later with rsp_dat=32'hDEADBEEF, o_rdy=1 -> o_vld=1 one cycle, o_addr=32'h0000_1000, outs_cnt goes 1 then 0.
2. Fill: 4 requests at 0x0, 0x4, 0x8, 0xC with no responses -> outs_cnt=4, req_rdy=0 on the 5th request. Four in-order responses -> o_addr sequence 0x0, 0x4, 0x8, 0xC.
3. Flush with 3 outstanding, then 3 responses -> o_vld stays 0, rsp_rdy=1 each cycle, outs_cnt reaches 0. A following request to 0x40 whose response arrives is delivered with o_addr=0x40.
4. Flush in the same cycle as a head response with o_rdy=1 -> o_vld=0 that cycle, the response is consumed, and the remaining entries are dropped.
5. Backpressure: o_rdy=0 with rsp_vld=1 -> rsp_rdy=0 and the response is held. Set o_rdy=1 -> delivered once.
6. Wrap: 10 back-to-back issue/retire pairs with simultaneous issue and retire -> outs_cnt constant at 1 and addresses match across the pointer wrap. Asserting rst_n=0 mid-stream -> outs_cnt=0 and o_vld=0 immediately.
